change_dispenser: RTL and testbench

- Sequences the coin hopper that pays out change after a vend or a cancel.
- Takes a change amount in nickel units and issues one coin-eject request at a time, largest denomination first.
- Skips denominations whose hopper reports empty and reports shortfall, ack timeout and abort.
- Sits between the vending_machine balance logic and the hopper drivers.

---
 rtl/vending_pkg.sv | 33 +++
 rtl/change_dispenser_coin_select.sv | 31 +++
 rtl/change_dispenser.sv | 139 +++++++++++++
 tb/tb_change_dispenser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath: coin codes, coin values in
// nickels and the change dispenser state encoding.
package vending_pkg;

   localparam logic [1:0] COIN_NICKEL  = 2'd0;
   localparam logic [1:0] COIN_DIME    = 2'd1;
   localparam logic [1:0] COIN_QUARTER = 2'd2;
   localparam logic [1:0] COIN_DOLLAR  = 2'd3;

   localparam logic [7:0] VAL_NICKEL  = 8'd1;
   localparam logic [7:0] VAL_DIME    = 8'd2;
   localparam logic [7:0] VAL_QUARTER = 8'd5;
   localparam logic [7:0] VAL_DOLLAR  = 8'd20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_REQ,
      ST_GAP,
      ST_DONE,
      ST_FAULT
   } state_e;

   function automatic logic [7:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_DOLLAR:  coin_value = VAL_DOLLAR;
         COIN_QUARTER: coin_value = VAL_QUARTER;
         COIN_DIME:    coin_value = VAL_DIME;
         default:      coin_value = VAL_NICKEL;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: the largest coin that fits in the unpaid amount and
// whose hopper still has stock.
module coin_select
   import vending_pkg::*;
(
   input  logic [7:0] remaining_i,
   input  logic [3:0] hopper_empty_i,
   output logic       valid_o,
   output logic [1:0] coin_o,
   output logic [7:0] value_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      valid_o = 1'b1;
      coin_o  = COIN_NICKEL;
      if (!hopper_empty_i[3] && remaining_i >= VAL_DOLLAR) begin
         coin_o = COIN_DOLLAR;
      end else if (!hopper_empty_i[2] && remaining_i >= VAL_QUARTER) begin
         coin_o = COIN_QUARTER;
      end else if (!hopper_empty_i[1] && remaining_i >= VAL_DIME) begin
         coin_o = COIN_DIME;
      end else if (!hopper_empty_i[0] && remaining_i >= VAL_NICKEL) begin
         coin_o = COIN_NICKEL;
      end else begin
         valid_o = 1'b0;
      end
      value_o = coin_value(coin_o);
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin-eject request at a time, largest coin first,
// with hopper ack timeout, shortfall detection and abort.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int GAP_CYCLES  = 2,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic [7:0] changeNickels,
   input  logic       abort,
   input  logic [3:0] hopperEmpty,
   input  logic       ejectAck,
   output logic       ejectReq,
   output logic [1:0] ejectCoin,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [7:0] remaining,
   output logic [7:0] coinsOut
);

   localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_e          state_q, state_d;
   logic [7:0]      rem_q, rem_d;
   logic [7:0]      coins_q, coins_d;
   logic [7:0]      val_q, val_d;
   logic [1:0]      coin_q, coin_d;
   logic            fault_q, fault_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            sel_valid;
   logic [1:0]      sel_coin;
   logic [7:0]      sel_value;

   coin_select u_coin_select (
      .remaining_i    (rem_q),
      .hopper_empty_i (hopperEmpty),
      .valid_o        (sel_valid),
      .coin_o         (sel_coin),
      .value_o        (sel_value)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      coins_d = coins_q;
      val_d   = val_q;
      coin_d  = coin_q;
      fault_d = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rem_d   = changeNickels;
               coins_d = '0;
               fault_d = 1'b0;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (abort || rem_q == '0) begin
               state_d = ST_DONE;
            end else if (sel_valid) begin
               coin_d  = sel_coin;
               val_d   = sel_value;
               state_d = ST_REQ;
            end else begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end
         end
         ST_REQ: begin
            // An ack on the same edge as abort still pays for the coin.
            if (ejectAck) begin
               rem_d   = rem_q - val_q;
               coins_d = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
               state_d = abort ? ST_DONE : ST_GAP;
            end else if (abort) begin
               state_d = ST_DONE;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_DONE;
            end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               state_d = ST_SELECT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Counter runs only while waiting in REQ or GAP and restarts on every state change.
      if ((state_q == ST_REQ || state_q == ST_GAP) && state_d == state_q) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   // NOTE: state is updated with non-blocking assignments; async reset clears everything at once.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         coins_q <= '0;
         val_q   <= '0;
         coin_q  <= COIN_NICKEL;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         coins_q <= coins_d;
         val_q   <= val_d;
         coin_q  <= coin_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ejectReq  = (state_q == ST_REQ);
   assign ejectCoin = coin_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
   assign fault     = fault_q;
   assign remaining = rem_q;
   assign coinsOut  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, empty-hopper skip,
// shortfall, ack timeout, abort, zero change and mid-transaction reset.
module tb_change_dispenser;

   logic       clk;
   logic       resetN;
   logic       start;
   logic [7:0] changeNickels;
   logic       abort;
   logic [3:0] hopperEmpty;
   logic       ejectAck;
   logic       ejectReq;
   logic [1:0] ejectCoin;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] remaining;
   logic [7:0] coinsOut;

   int checks = 0;
   int errors = 0;

   change_dispenser #(
      .GAP_CYCLES  (2),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .start         (start),
      .changeNickels (changeNickels),
      .abort         (abort),
      .hopperEmpty   (hopperEmpty),
      .ejectAck      (ejectAck),
      .ejectReq      (ejectReq),
      .ejectCoin     (ejectCoin),
      .busy          (busy),
      .done          (done),
      .fault         (fault),
      .remaining     (remaining),
      .coinsOut      (coinsOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Results of the last pay() run.
   int         n_coins;
   int         req_cycles;
   bit         saw_done;
   logic [1:0] coin_seq [8];
   logic [7:0] rem_seq  [8];

   // Starts a transaction and plays the hopper: acks in the second cycle of
   // each request when do_ack is set. Returns at the negedge showing done.
   task automatic pay(input logic [7:0] n, input logic [3:0] empty, input bit do_ack);
      int  ack_wait;
      bit  acked;
      n_coins    = 0;
      req_cycles = 0;
      saw_done   = 1'b0;
      ack_wait   = 0;
      acked      = 1'b0;
      @(negedge clk);
      changeNickels = n;
      hopperEmpty   = empty;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (acked) begin
            rem_seq[n_coins-1] = remaining;
            acked = 1'b0;
         end
         if (done) begin
            saw_done = 1'b1;
            break;
         end
         ejectAck = 1'b0;
         if (ejectReq) begin
            req_cycles++;
            if (do_ack && ack_wait == 1) begin
               ejectAck = 1'b1;
               if (n_coins < 8) coin_seq[n_coins] = ejectCoin;
               n_coins++;
               acked    = 1'b1;
               ack_wait = 0;
            end else begin
               ack_wait++;
            end
         end
         @(negedge clk);
      end
      ejectAck = 1'b0;
      check("done_reached", int'(saw_done), 1);
   endtask

   initial begin
      resetN        = 1'b0;
      start         = 1'b0;
      changeNickels = '0;
      abort         = 1'b0;
      hopperEmpty   = '0;
      ejectAck      = 1'b0;
      #22;
      check("rst_req",   int'(ejectReq),  0);
      check("rst_busy",  int'(busy),      0);
      check("rst_done",  int'(done),      0);
      check("rst_fault", int'(fault),     0);
      check("rst_rem",   int'(remaining), 0);
      check("rst_coins", int'(coinsOut),  0);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);

      // Greedy: 28 = 20 + 5 + 2 + 1.
      pay(8'd28, 4'b0000, 1'b1);
      check("base_ncoins", n_coins, 4);
      check("base_c0", int'(coin_seq[0]), 3);
      check("base_c1", int'(coin_seq[1]), 2);
      check("base_c2", int'(coin_seq[2]), 1);
      check("base_c3", int'(coin_seq[3]), 0);
      check("base_r0", int'(rem_seq[0]), 8);
      check("base_r1", int'(rem_seq[1]), 3);
      check("base_r2", int'(rem_seq[2]), 1);
      check("base_r3", int'(rem_seq[3]), 0);
      check("base_coinsOut", int'(coinsOut), 4);
      check("base_fault", int'(fault), 0);
      @(negedge clk);
      check("base_done_once", int'(done), 0);
      check("base_idle", int'(busy), 0);

      // Quarter hopper empty: 8 paid as four dimes.
      pay(8'd8, 4'b0100, 1'b1);
      check("skip_ncoins", n_coins, 4);
      for (int i = 0; i < 4; i++) check("skip_coin", int'(coin_seq[i]), 1);
      check("skip_rem", int'(remaining), 0);
      check("skip_fault", int'(fault), 0);

      // Shortfall: one dime, then nothing fits 1 nickel.
      pay(8'd3, 4'b0001, 1'b1);
      check("short_ncoins", n_coins, 1);
      check("short_coin", int'(coin_seq[0]), 1);
      check("short_rem", int'(remaining), 1);
      check("short_coinsOut", int'(coinsOut), 1);
      check("short_fault", int'(fault), 1);
      @(negedge clk);
      check("short_fault_sticky", int'(fault), 1);
      check("short_done_once", int'(done), 0);

      // Ack timeout after exactly 4 request cycles.
      pay(8'd20, 4'b0000, 1'b0);
      check("tmo_req_cycles", req_cycles, 4);
      check("tmo_fault", int'(fault), 1);
      check("tmo_rem", int'(remaining), 20);
      check("tmo_coinsOut", int'(coinsOut), 0);

      // Abort coinciding with the first ack.
      @(negedge clk);
      changeNickels = 8'd40;
      hopperEmpty   = 4'b0000;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_fault_cleared", int'(fault), 0);
      check("abort_sel_noreq", int'(ejectReq), 0);
      @(negedge clk);
      check("abort_req_latency", int'(ejectReq), 1);
      check("abort_req_coin", int'(ejectCoin), 3);
      ejectAck = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      ejectAck = 1'b0;
      abort    = 1'b0;
      check("abort_done", int'(done), 1);
      check("abort_req_drop", int'(ejectReq), 0);
      check("abort_rem", int'(remaining), 20);
      check("abort_coinsOut", int'(coinsOut), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_quiet_req", int'(ejectReq), 0);
         check("abort_quiet_done", int'(done), 0);
      end

      // Zero change: done two cycles after start, no request.
      changeNickels = 8'd0;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_c1_done", int'(done), 0);
      check("zero_c1_req", int'(ejectReq), 0);
      @(negedge clk);
      check("zero_c2_done", int'(done), 1);
      check("zero_c2_req", int'(ejectReq), 0);
      check("zero_coinsOut", int'(coinsOut), 0);
      @(negedge clk);

      // Start while busy is ignored; then reset in the middle of REQ.
      changeNickels = 8'd20;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("busy_req", int'(ejectReq), 1);
      changeNickels = 8'd99;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_ignored", int'(remaining), 20);
      check("busy_still_req", int'(ejectReq), 1);
      #2;
      resetN = 1'b0;
      #1;
      check("mid_rst_req", int'(ejectReq), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_rem", int'(remaining), 0);
      check("mid_rst_coins", int'(coinsOut), 0);
      check("mid_rst_done", int'(done), 0);
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle", int'(busy), 0);
         check("post_rst_done", int'(done), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
